// File: rtl/match_round_controller_if.sv
// Round controller bus: tick, health-manager inputs, buttons, and
// round/score outputs.
interface match_round_controller_if;
  logic       tick;
  logic [1:0] winner;
  logic [8:0] health_1;
  logic [8:0] health_2;
  logic       continue_btn;
  logic       force_reset;
  logic       round_reset;
  logic       freeze;
  logic [1:0] countdown;
  logic [6:0] round_time;
  logic [2:0] round_num;
  logic [1:0] score_p1;
  logic [1:0] score_p2;
  logic [1:0] round_result;
  logic       match_over;
  logic [1:0] match_winner;

  modport master (
    output tick, winner, health_1, health_2,
    output continue_btn, force_reset,
    input  round_reset, freeze, countdown,
    input  round_time, round_num, score_p1,
    input  score_p2, round_result, match_over,
    input  match_winner
  );

  modport slave (
    input  tick, winner, health_1, health_2,
    input  continue_btn, force_reset,
    output round_reset, freeze, countdown,
    output round_time, round_num, score_p1,
    output score_p2, round_result, match_over,
    output match_winner
  );
endinterface

// File: rtl/match_round_controller.sv
// Best-of-N round sequencer: reset pulse, countdown, fight, scoring.
// MATCH_TIMEOUT_EN enables the round timer and health tiebreak.
module match_round_controller #(
  parameter int TICKS_PER_SEC     = 20,
  parameter int ROUND_SECONDS     = 99,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int ROUNDS_TO_WIN     = 2,
  parameter int RESET_PULSE_TICKS = 2,
  parameter int END_HOLD_TICKS    = 40,
  parameter int HOLD_TICKS        = 40
) (
  input logic clk,
  input logic reset_n,
  match_round_controller_if.slave bus
);
  typedef enum logic [2:0] {
    S_RESET, S_COUNTDOWN, S_FIGHT, S_ROUND_END, S_MATCH_OVER
  } state_t;

  localparam logic [15:0] L_TPS   = 16'(TICKS_PER_SEC - 1);
  localparam logic [15:0] L_PULSE = 16'(RESET_PULSE_TICKS - 1);
  localparam logic [15:0] L_END   = 16'(END_HOLD_TICKS - 1);
  localparam logic [15:0] L_HOLD  = 16'(HOLD_TICKS - 1);
  localparam logic [1:0]  L_CD    = 2'(COUNTDOWN_SECONDS);
  localparam logic [6:0]  L_RS    = 7'(ROUND_SECONDS);
  localparam logic [1:0]  L_RTW   = 2'(ROUNDS_TO_WIN);

  state_t      r_state, w_state;
  logic [15:0] r_cnt, w_cnt;
  logic [15:0] r_hold, w_hold;
  logic [15:0] r_force, w_force;
  logic        r_round_reset, w_round_reset;
  logic        r_freeze, w_freeze;
  logic [1:0]  r_countdown, w_countdown;
  logic [6:0]  r_round_time, w_round_time;
  logic [2:0]  r_round_num, w_round_num;
  logic [1:0]  r_score_p1, w_score_p1;
  logic [1:0]  r_score_p2, w_score_p2;
  logic [1:0]  r_result, w_result;
  logic        r_match_over, w_match_over;
  logic [1:0]  r_match_winner, w_match_winner;
  logic [1:0]  w_res;
  logic        w_clear;

`ifndef MATCH_TIMEOUT_EN
  logic w_unused_health;
  assign w_unused_health = ^{bus.health_1, bus.health_2};
`endif

  // State and registered outputs; only tick edges change them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_RESET;
      r_cnt          <= '0;
      r_hold         <= '0;
      r_force        <= '0;
      r_round_reset  <= 1'b1;
      r_freeze       <= 1'b1;
      r_countdown    <= L_CD;
      r_round_time   <= L_RS;
      r_round_num    <= 3'd1;
      r_score_p1     <= '0;
      r_score_p2     <= '0;
      r_result       <= '0;
      r_match_over   <= 1'b0;
      r_match_winner <= '0;
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      r_hold         <= w_hold;
      r_force        <= w_force;
      r_round_reset  <= w_round_reset;
      r_freeze       <= w_freeze;
      r_countdown    <= w_countdown;
      r_round_time   <= w_round_time;
      r_round_num    <= w_round_num;
      r_score_p1     <= w_score_p1;
      r_score_p2     <= w_score_p2;
      r_result       <= w_result;
      r_match_over   <= w_match_over;
      r_match_winner <= w_match_winner;
    end
  end

  // Next state, counters, scores; force-reset clear overrides all.
  always_comb begin
    w_state        = r_state;
    w_cnt          = r_cnt;
    w_hold         = r_hold;
    w_force        = r_force;
    w_countdown    = r_countdown;
    w_round_time   = r_round_time;
    w_round_num    = r_round_num;
    w_score_p1     = r_score_p1;
    w_score_p2     = r_score_p2;
    w_result       = r_result;
    w_match_winner = r_match_winner;
    w_res          = 2'b00;
    w_clear        = 1'b0;
    if (bus.tick) begin
      w_force = bus.force_reset ? r_force + 16'd1 : 16'd0;
      w_hold  = 16'd0;
      unique case (r_state)
        S_RESET: begin
          if (r_cnt == L_PULSE) begin
            w_cnt       = '0;
            w_state     = S_COUNTDOWN;
            w_countdown = L_CD;
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
        S_COUNTDOWN: begin
          if (r_cnt == L_TPS) begin
            w_cnt = '0;
            if (r_countdown == 2'd1) begin
              w_state      = S_FIGHT;
              w_countdown  = 2'd0;
              w_round_time = L_RS;
            end else begin
              w_countdown = r_countdown - 2'd1;
            end
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
        S_FIGHT: begin
          if (bus.winner != 2'b00) begin
            w_res = bus.winner;
          end
`ifdef MATCH_TIMEOUT_EN
          else if (r_cnt == L_TPS) begin
            w_cnt        = '0;
            w_round_time = r_round_time - 7'd1;
            if (r_round_time == 7'd1) begin
              if (bus.health_1 > bus.health_2)
                w_res = 2'b01;
              else if (bus.health_1 < bus.health_2)
                w_res = 2'b10;
              else
                w_res = 2'b11;
            end
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
`endif
          if (w_res != 2'b00) begin
            w_state  = S_ROUND_END;
            w_cnt    = '0;
            w_result = w_res;
            if (w_res == 2'b01 && r_score_p1 != L_RTW)
              w_score_p1 = r_score_p1 + 2'd1;
            if (w_res == 2'b10 && r_score_p2 != L_RTW)
              w_score_p2 = r_score_p2 + 2'd1;
          end
        end
        S_ROUND_END: begin
          if (r_cnt == L_END) begin
            w_cnt = '0;
            if (r_score_p1 == L_RTW) begin
              w_state        = S_MATCH_OVER;
              w_match_winner = 2'b01;
            end else if (r_score_p2 == L_RTW) begin
              w_state        = S_MATCH_OVER;
              w_match_winner = 2'b10;
            end else begin
              w_state      = S_RESET;
              w_countdown  = L_CD;
              w_round_time = L_RS;
              if (r_round_num != 3'd7)
                w_round_num = r_round_num + 3'd1;
            end
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
        S_MATCH_OVER: begin
          if (bus.continue_btn) begin
            if (r_hold == L_HOLD)
              w_clear = 1'b1;
            else
              w_hold = r_hold + 16'd1;
          end
        end
        default: w_state = S_RESET;
      endcase
      if (bus.force_reset && r_force == L_HOLD)
        w_clear = 1'b1;
      if (w_clear) begin
        w_state        = S_RESET;
        w_cnt          = '0;
        w_hold         = '0;
        w_force        = '0;
        w_countdown    = L_CD;
        w_round_time   = L_RS;
        w_round_num    = 3'd1;
        w_score_p1     = '0;
        w_score_p2     = '0;
        w_result       = '0;
        w_match_winner = '0;
      end
    end
    w_round_reset = (w_state == S_RESET);
    w_freeze      = (w_state != S_FIGHT);
    w_match_over  = (w_state == S_MATCH_OVER);
  end

  assign bus.round_reset  = r_round_reset;
  assign bus.freeze       = r_freeze;
  assign bus.countdown    = r_countdown;
  assign bus.round_time   = r_round_time;
  assign bus.round_num    = r_round_num;
  assign bus.score_p1     = r_score_p1;
  assign bus.score_p2     = r_score_p2;
  assign bus.round_result = r_result;
  assign bus.match_over   = r_match_over;
  assign bus.match_winner = r_match_winner;
endmodule

// File: tb/tb_match_round_controller.sv
// Scoreboard bench for match_round_controller.
// Build with +define+MATCH_TIMEOUT_EN to cover the round timer.
module tb_match_round_controller;
  logic clk;
  logic reset_n;
  match_round_controller_if bus_if();

  match_round_controller #(
    .TICKS_PER_SEC(2), .ROUND_SECONDS(3),
    .COUNTDOWN_SECONDS(2), .ROUNDS_TO_WIN(2),
    .RESET_PULSE_TICKS(2), .END_HOLD_TICKS(4),
    .HOLD_TICKS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if)
  );

`ifdef MATCH_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  typedef struct {
    logic [1:0]  win;
    logic        btn;
    logic        frc;
    int          nt;
    logic [22:0] exp;
    string       nm;
  } step_t;

  step_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [2:0] m_rn;
  logic [1:0] m_s1, m_s2, m_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] mk(
    input logic rr, input logic frz, input logic [1:0] cd,
    input logic [6:0] rt, input logic [2:0] rn,
    input logic [1:0] s1, input logic [1:0] s2,
    input logic [1:0] res, input logic mo,
    input logic [1:0] mw);
    return {rr, frz, cd, rt, rn, s1, s2, res, mo, mw};
  endfunction

  function automatic logic [22:0] snap();
    return {bus_if.round_reset, bus_if.freeze,
            bus_if.countdown, bus_if.round_time,
            bus_if.round_num, bus_if.score_p1,
            bus_if.score_p2, bus_if.round_result,
            bus_if.match_over, bus_if.match_winner};
  endfunction

  function automatic step_t st(
    input logic [1:0] win, input logic btn, input logic frc,
    input int nt, input logic [22:0] exp, input string nm);
    step_t s;
    s.win = win; s.btn = btn; s.frc = frc;
    s.nt = nt; s.exp = exp; s.nm = nm;
    return s;
  endfunction

  task automatic pulse_tick();
    @(negedge clk); bus_if.tick = 1'b1;
    @(negedge clk); bus_if.tick = 1'b0;
  endtask

  task automatic goto_fight();
    bus_if.winner = 2'b00;
    repeat (6) pulse_tick();
  endtask

  task automatic test_reset();
    logic [22:0] g;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    g = snap();
    n_checks++;
    if (g !== mk(1,1,2,3,1,0,0,0,0,0)) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h",
               g, mk(1,1,2,3,1,0,0,0,0,0));
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_start();
    step_t s;
    logic [22:0] g;
    sb_q.push_back(st(1,0,0,1,mk(1,1,2,3,1,0,0,0,0,0),"start_t1"));
    sb_q.push_back(st(1,0,0,1,mk(0,1,2,3,1,0,0,0,0,0),"start_t2"));
    sb_q.push_back(st(1,0,0,1,mk(0,1,2,3,1,0,0,0,0,0),"start_t3"));
    sb_q.push_back(st(1,0,0,1,mk(0,1,1,3,1,0,0,0,0,0),"start_t4"));
    sb_q.push_back(st(1,0,0,1,mk(0,1,1,3,1,0,0,0,0,0),"start_t5"));
    sb_q.push_back(st(1,0,0,1,mk(0,0,0,3,1,0,0,0,0,0),"start_t6"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus_if.winner = s.win;
      bus_if.continue_btn = s.btn;
      bus_if.force_reset = s.frc;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
  endtask

  task automatic test_ko();
    step_t s;
    logic [22:0] g;
    sb_q.push_back(st(1,0,0,1,mk(0,1,0,3,1,1,0,1,0,0),"ko_entry"));
    sb_q.push_back(st(0,0,0,3,mk(0,1,0,3,1,1,0,1,0,0),"ko_hold"));
    sb_q.push_back(st(0,0,0,1,mk(1,1,2,3,2,1,0,1,0,0),"ko_next"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus_if.winner = s.win;
      bus_if.continue_btn = s.btn;
      bus_if.force_reset = s.frc;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
  endtask

  task automatic test_match_over();
    step_t s;
    logic [22:0] g;
    sb_q.push_back(st(0,0,0,6,mk(0,0,0,3,2,1,0,1,0,0),"mo_fight2"));
    sb_q.push_back(st(2,0,0,1,mk(0,1,0,3,2,1,1,2,0,0),"mo_ko1"));
    sb_q.push_back(st(0,0,0,4,mk(1,1,2,3,3,1,1,2,0,0),"mo_r3"));
    sb_q.push_back(st(0,0,0,6,mk(0,0,0,3,3,1,1,2,0,0),"mo_fight3"));
    sb_q.push_back(st(2,0,0,1,mk(0,1,0,3,3,1,2,2,0,0),"mo_ko2"));
    sb_q.push_back(st(0,0,0,4,mk(0,1,0,3,3,1,2,2,1,2),"mo_enter"));
    sb_q.push_back(st(2,0,0,3,mk(0,1,0,3,3,1,2,2,1,2),"mo_stay"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus_if.winner = s.win;
      bus_if.continue_btn = s.btn;
      bus_if.force_reset = s.frc;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
  endtask

  task automatic test_continue();
    step_t s;
    logic [22:0] g;
    sb_q.push_back(st(0,1,0,2,mk(0,1,0,3,3,1,2,2,1,2),"cont_h2"));
    sb_q.push_back(st(0,0,0,1,mk(0,1,0,3,3,1,2,2,1,2),"cont_rel"));
    sb_q.push_back(st(0,1,0,2,mk(0,1,0,3,3,1,2,2,1,2),"cont_h2b"));
    sb_q.push_back(st(0,1,0,1,mk(1,1,2,3,1,0,0,0,0,0),"cont_clr"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus_if.winner = s.win;
      bus_if.continue_btn = s.btn;
      bus_if.force_reset = s.frc;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
    bus_if.continue_btn = 1'b0;
  endtask

  task automatic test_timer();
    step_t s;
    logic [22:0] g;
    bus_if.health_1 = 9'd100;
    bus_if.health_2 = 9'd150;
    goto_fight();
`ifdef MATCH_TIMEOUT_EN
    sb_q.push_back(st(0,0,0,1,mk(0,0,0,3,1,0,0,0,0,0),"tmo_t1"));
    sb_q.push_back(st(0,0,0,1,mk(0,0,0,2,1,0,0,0,0,0),"tmo_t2"));
    sb_q.push_back(st(0,0,0,1,mk(0,0,0,2,1,0,0,0,0,0),"tmo_t3"));
    sb_q.push_back(st(0,0,0,1,mk(0,0,0,1,1,0,0,0,0,0),"tmo_t4"));
    sb_q.push_back(st(0,0,0,1,mk(0,0,0,1,1,0,0,0,0,0),"tmo_t5"));
    sb_q.push_back(st(0,0,0,1,mk(0,1,0,0,1,0,1,2,0,0),"tmo_p2"));
    sb_q.push_back(st(0,0,0,4,mk(1,1,2,3,2,0,1,2,0,0),"tmo_r2"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus_if.winner = s.win;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
    bus_if.health_1 = 9'd150;
    goto_fight();
    sb_q.push_back(st(0,0,0,6,mk(0,1,0,0,2,0,1,3,0,0),"tmo_draw"));
    sb_q.push_back(st(0,0,0,4,mk(1,1,2,3,3,0,1,3,0,0),"tmo_r3"));
    sb_q.push_back(st(0,0,0,6,mk(0,0,0,3,3,0,1,3,0,0),"tmo_f3"));
    sb_q.push_back(st(0,0,0,5,mk(0,0,0,1,3,0,1,3,0,0),"tmo_pre"));
    sb_q.push_back(st(1,0,0,1,mk(0,1,0,1,3,1,1,1,0,0),"tmo_koprio"));
    sb_q.push_back(st(0,0,0,4,mk(1,1,2,3,4,1,1,1,0,0),"tmo_r4"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      if (s.nm == "tmo_pre") bus_if.health_1 = 9'd100;
      bus_if.winner = s.win;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
    m_rn = 3'd4; m_s1 = 2'd1; m_s2 = 2'd1; m_res = 2'b01;
`else
    for (int i = 0; i < 4; i++)
      sb_q.push_back(st(0,0,0,5,mk(0,0,0,3,1,0,0,0,0,0),
                        $sformatf("hold_t%0d", i)));
    sb_q.push_back(st(1,0,0,1,mk(0,1,0,3,1,1,0,1,0,0),"hold_ko"));
    sb_q.push_back(st(0,0,0,4,mk(1,1,2,3,2,1,0,1,0,0),"hold_r2"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus_if.winner = s.win;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
    m_rn = 3'd2; m_s1 = 2'd1; m_s2 = 2'd0; m_res = 2'b01;
`endif
    bus_if.winner = 2'b00;
  endtask

  task automatic test_force();
    step_t s;
    logic [22:0] g;
    logic [6:0] rt2;
    rt2 = TMO ? 7'd2 : 7'd3;
    goto_fight();
    sb_q.push_back(st(0,0,1,1,
      mk(0,0,0,3,m_rn,m_s1,m_s2,m_res,0,0),"force_t1"));
    sb_q.push_back(st(0,0,1,1,
      mk(0,0,0,rt2,m_rn,m_s1,m_s2,m_res,0,0),"force_t2"));
    sb_q.push_back(st(0,0,1,1,mk(1,1,2,3,1,0,0,0,0,0),"force_clr"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus_if.winner = s.win;
      bus_if.force_reset = s.frc;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
    bus_if.force_reset = 1'b0;
  endtask

  task automatic test_async_reset();
    step_t s;
    logic [22:0] g;
    goto_fight();
    sb_q.push_back(st(1,0,0,1,mk(0,1,0,3,1,1,0,1,0,0),"ar_ko"));
    sb_q.push_back(st(0,0,0,4,mk(1,1,2,3,2,1,0,1,0,0),"ar_r2"));
    sb_q.push_back(st(0,0,0,7,mk(0,0,0,TMO ? 7'd3 : 7'd3,2,1,0,1,0,0),
                      "ar_fight"));
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus_if.winner = s.win;
      repeat (s.nt) pulse_tick();
      g = snap(); n_checks++;
      if (g !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.nm, g, s.exp);
      end
    end
    #2 reset_n = 1'b0;
    #1 g = snap(); n_checks++;
    if (g !== mk(1,1,2,3,1,0,0,0,0,0)) begin
      n_fail++;
      $display("FAIL ar_async: got %h expected %h",
               g, mk(1,1,2,3,1,0,0,0,0,0));
    end
    @(negedge clk); reset_n = 1'b1;
    pulse_tick();
    g = snap(); n_checks++;
    if (g !== mk(1,1,2,3,1,0,0,0,0,0)) begin
      n_fail++;
      $display("FAIL ar_t1: got %h expected %h",
               g, mk(1,1,2,3,1,0,0,0,0,0));
    end
    pulse_tick();
    g = snap(); n_checks++;
    if (g !== mk(0,1,2,3,1,0,0,0,0,0)) begin
      n_fail++;
      $display("FAIL ar_t2: got %h expected %h",
               g, mk(0,1,2,3,1,0,0,0,0,0));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus_if.tick = 1'b0;
    bus_if.winner = 2'b00;
    bus_if.health_1 = 9'd200;
    bus_if.health_2 = 9'd200;
    bus_if.continue_btn = 1'b0;
    bus_if.force_reset = 1'b0;
    m_rn = 3'd1; m_s1 = 2'd0; m_s2 = 2'd0; m_res = 2'b00;
    test_reset();
    test_round_start();
    test_ko();
    test_match_over();
    test_continue();
    test_timer();
    test_force();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
